// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I decode stage:
//   - opcode[6:2] and funct3 constants
//   - wb_mux_sel / imm_type encodings used by the execute stage
//   - dec_bundle_t: the decoded control bundle (plus PC) held in the FIFO
//   - dec_state_e: FENCE serialisation FSM states
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam int unsigned DEC_PC_W = 32;

   // opcode[6:2]; opcode[1:0] must be 2'b11 for any 32-bit instruction
   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [2:0] F3_PRIV      = 3'b000;  // ECALL / EBREAK
   localparam logic [2:0] F3_SLLI      = 3'b001;
   localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

   // Write-back source select
   localparam logic [2:0] WB_ALU       = 3'b000;
   localparam logic [2:0] WB_LOAD      = 3'b001;
   localparam logic [2:0] WB_IMM       = 3'b010;  // LUI
   localparam logic [2:0] WB_IADDER    = 3'b011;  // AUIPC
   localparam logic [2:0] WB_CSR       = 3'b100;
   localparam logic [2:0] WB_PC_PLUS_4 = 3'b101;  // JAL / JALR link

   // Immediate format
   localparam logic [2:0] IMM_R   = 3'b000;
   localparam logic [2:0] IMM_I   = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_U   = 3'b100;
   localparam logic [2:0] IMM_J   = 3'b101;
   localparam logic [2:0] IMM_CSR = 3'b110;

   typedef struct packed {
      logic [DEC_PC_W-1:0] pc;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [2:0]          wb_mux_sel;
      logic [2:0]          imm_type;
      logic [2:0]          csr_op;
      logic [3:0]          alu_opcode;
      logic [1:0]          load_size;
      logic                alu_src;
      logic                iadder_src;
      logic                rf_wr_en;
      logic                mem_wr_req;
      logic                load_unsigned;
      logic                csr_wr_en;
      logic                illegal_instr;
   } dec_bundle_t;

   typedef enum logic [1:0] {
      ST_RUN         = 2'd0,
      ST_FENCE_DRAIN = 2'd1,
      ST_FENCE_IDLE  = 2'd2
   } dec_state_e;

endpackage

// File: rtl/decode_fifo.sv
// -----------------------------------------------------------------------------
// decode_fifo
// Synchronous DEPTH x WIDTH FIFO holding decoded bundles.
//   clk_in, reset_n_in : clock / async active-low reset (empties the FIFO)
//   push_in, wr_data_in: write; ignored when full
//   pop_in             : read-advance; ignored when empty
//   flush_in           : clears pointers and count, overrides push/pop
//   rd_data_out        : head entry, forced to zero while empty
//   full_out, empty_out, count_out : fill status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module decode_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_in,
   input  logic                     reset_n_in,
   input  logic                     push_in,
   input  logic [WIDTH-1:0]         wr_data_in,
   input  logic                     pop_in,
   input  logic                     flush_in,
   output logic [WIDTH-1:0]         rd_data_out,
   output logic                     full_out,
   output logic                     empty_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full_out  = (count_q == CW'(DEPTH));
   assign empty_out = (count_q == '0);
   assign count_out = count_q;

   assign do_push = push_in & ~full_out  & ~flush_in;
   assign do_pop  = pop_in  & ~empty_out & ~flush_in;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; empty_out gates the read port so stale data never escapes.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_in;
   end

   assign rd_data_out = empty_out ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered, flow-controlled RV32I decode stage with FENCE serialisation.
//   instr_valid_in / instr_ready_out / instr_in / pc_in : upstream handshake
//   flush_in      : drop all buffered entries, return FSM to RUN
//   mem_idle_in   : load/store unit quiescent (releases a FENCE)
//   dec_valid_out / dec_ready_in + bundle outputs       : downstream handshake
//   occupancy_out : FIFO fill;  illegal_cnt_out : saturating illegal count
// Optional feature macro: DECODE_CSR_EN enables CSR access decoding; without
// it SYSTEM instructions with funct3 != 0 are flagged illegal.
// -----------------------------------------------------------------------------
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned PC_W  = DEC_PC_W,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic                   clk_in,
   input  logic                   reset_n_in,
   input  logic                   instr_valid_in,
   output logic                   instr_ready_out,
   input  logic [31:0]            instr_in,
   input  logic [PC_W-1:0]        pc_in,
   input  logic                   flush_in,
   input  logic                   mem_idle_in,
   output logic                   dec_valid_out,
   input  logic                   dec_ready_in,
   output logic [PC_W-1:0]        pc_out,
   output logic [4:0]             rs1_out,
   output logic [4:0]             rs2_out,
   output logic [4:0]             rd_out,
   output logic [2:0]             wb_mux_sel_out,
   output logic [2:0]             imm_type_out,
   output logic [2:0]             csr_op_out,
   output logic [3:0]             alu_opcode_out,
   output logic [1:0]             load_size_out,
   output logic                   alu_src_out,
   output logic                   iadder_src_out,
   output logic                   rf_wr_en_out,
   output logic                   mem_wr_req_out,
   output logic                   load_unsigned_out,
   output logic                   csr_wr_en_out,
   output logic                   illegal_instr_out,
   output logic [$clog2(DEPTH):0] occupancy_out,
   output logic [CNT_W-1:0]       illegal_cnt_out
);

   // ---------------- combinational decode ----------------
   logic [4:0] opc;
   logic [2:0] funct3;
   logic       op_ok;
   logic       is_load, is_misc_mem, is_op_imm, is_auipc, is_store, is_op;
   logic       is_lui, is_branch, is_jalr, is_jal, is_system, is_priv, is_csr;
   logic       is_shift_imm, illegal;
   logic       unused_instr_bits;
   dec_bundle_t dec, head;

   assign opc    = instr_in[6:2];
   assign funct3 = instr_in[14:12];
   assign op_ok  = (instr_in[1:0] == 2'b11);

   assign is_load     = op_ok && (opc == OPC_LOAD);
   assign is_misc_mem = op_ok && (opc == OPC_MISC_MEM);
   assign is_op_imm   = op_ok && (opc == OPC_OP_IMM);
   assign is_auipc    = op_ok && (opc == OPC_AUIPC);
   assign is_store    = op_ok && (opc == OPC_STORE);
   assign is_op       = op_ok && (opc == OPC_OP);
   assign is_lui      = op_ok && (opc == OPC_LUI);
   assign is_branch   = op_ok && (opc == OPC_BRANCH);
   assign is_jalr     = op_ok && (opc == OPC_JALR);
   assign is_jal      = op_ok && (opc == OPC_JAL);
   assign is_system   = op_ok && (opc == OPC_SYSTEM);
   assign is_priv     = is_system && (funct3 == F3_PRIV);
`ifdef DECODE_CSR_EN
   assign is_csr      = is_system && (funct3 != F3_PRIV);
`else
   assign is_csr      = 1'b0;
`endif

   // Shift-immediates keep funct7[5] (SRAI vs SRLI); other I-type ALU ops carry immediate bits there.
   assign is_shift_imm = (funct3 == F3_SLLI) || (funct3 == F3_SRLI_SRAI);

   assign illegal = ~(is_load | is_misc_mem | is_op_imm | is_auipc | is_store | is_op |
                      is_lui | is_branch | is_jalr | is_jal | is_priv | is_csr);

   // Immediate bits are rebuilt by the execute-stage immediate generator.
   assign unused_instr_bits = &{1'b0, instr_in[31], instr_in[29:25]};

   always_comb begin
      dec               = '0;
      dec.pc            = DEC_PC_W'(pc_in);
      dec.rs1           = instr_in[19:15];
      dec.rs2           = instr_in[24:20];
      dec.rd            = instr_in[11:7];

      if (is_load)               dec.wb_mux_sel = WB_LOAD;
      else if (is_lui)           dec.wb_mux_sel = WB_IMM;
      else if (is_auipc)         dec.wb_mux_sel = WB_IADDER;
      else if (is_jal | is_jalr) dec.wb_mux_sel = WB_PC_PLUS_4;
      else if (is_csr)           dec.wb_mux_sel = WB_CSR;
      else                       dec.wb_mux_sel = WB_ALU;

      if (is_op_imm | is_load | is_jalr) dec.imm_type = IMM_I;
      else if (is_store)                 dec.imm_type = IMM_S;
      else if (is_branch)                dec.imm_type = IMM_B;
      else if (is_lui | is_auipc)        dec.imm_type = IMM_U;
      else if (is_jal)                   dec.imm_type = IMM_J;
      else if (is_csr)                   dec.imm_type = IMM_CSR;
      else                               dec.imm_type = IMM_R;

      dec.alu_opcode    = {instr_in[30] & ~(is_op_imm & ~is_shift_imm), funct3};
      dec.alu_src       = instr_in[5];
      dec.iadder_src    = is_load | is_store | is_jalr;
      dec.load_size     = funct3[1:0];
      dec.load_unsigned = funct3[2];
      dec.csr_op        = is_csr ? funct3 : 3'b000;
      // Write enables are explicitly masked by illegal so a bad encoding can never commit state.
      dec.rf_wr_en      = (is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm |
                           is_load | is_csr) & ~illegal;
      dec.mem_wr_req    = is_store & ~illegal;
      dec.csr_wr_en     = is_csr & ~illegal;
      dec.illegal_instr = illegal;
   end

   // ---------------- handshake and FIFO ----------------
   dec_state_e         state_q, state_d;
   logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;
   logic               fifo_full, fifo_empty, push, pop;

   // Ready is a function of registered state only: a pop never frees a slot in the same cycle.
   assign instr_ready_out = (state_q == ST_RUN) & ~fifo_full;
   assign push            = instr_valid_in & instr_ready_out;
   assign dec_valid_out   = ~fifo_empty;
   assign pop             = dec_valid_out & dec_ready_in;

   decode_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(dec_bundle_t))
   ) u_fifo (
      .clk_in      (clk_in),
      .reset_n_in  (reset_n_in),
      .push_in     (push),
      .wr_data_in  (dec),
      .pop_in      (pop),
      .flush_in    (flush_in),
      .rd_data_out (head),
      .full_out    (fifo_full),
      .empty_out   (fifo_empty),
      .count_out   (occupancy_out)
   );

   // ---------------- FENCE FSM and illegal counter ----------------
   always_comb begin
      state_d = state_q;
      if (flush_in) begin
         state_d = ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN:         if (push && is_misc_mem) state_d = ST_FENCE_DRAIN;
            // Empty here means the FENCE itself has left for execute.
            ST_FENCE_DRAIN: if (fifo_empty)          state_d = ST_FENCE_IDLE;
            ST_FENCE_IDLE:  if (mem_idle_in)         state_d = ST_RUN;
            default:                                 state_d = ST_RUN;
         endcase
      end

      illegal_cnt_d = illegal_cnt_q;
      if (push && illegal && !flush_in && (illegal_cnt_q != '1))
         illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q       <= ST_RUN;
         illegal_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign illegal_cnt_out = illegal_cnt_q;

   // ---------------- head bundle to ports ----------------
   assign pc_out            = PC_W'(head.pc);
   assign rs1_out           = head.rs1;
   assign rs2_out           = head.rs2;
   assign rd_out            = head.rd;
   assign wb_mux_sel_out    = head.wb_mux_sel;
   assign imm_type_out      = head.imm_type;
   assign csr_op_out        = head.csr_op;
   assign alu_opcode_out    = head.alu_opcode;
   assign load_size_out     = head.load_size;
   assign alu_src_out       = head.alu_src;
   assign iadder_src_out    = head.iadder_src;
   assign rf_wr_en_out      = head.rf_wr_en;
   assign mem_wr_req_out    = head.mem_wr_req;
   assign load_unsigned_out = head.load_unsigned;
   assign csr_wr_en_out     = head.csr_wr_en;
   assign illegal_instr_out = head.illegal_instr;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, all compared against a queue-based reference model of the stage.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_stage;

   localparam int PC_W  = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk_in         = 1'b0;
   logic              reset_n_in     = 1'b0;
   logic              instr_valid_in = 1'b0;
   logic              instr_ready_out;
   logic [31:0]       instr_in       = '0;
   logic [PC_W-1:0]   pc_in          = '0;
   logic              flush_in       = 1'b0;
   logic              mem_idle_in    = 1'b1;
   logic              dec_valid_out;
   logic              dec_ready_in   = 1'b0;
   logic [PC_W-1:0]   pc_out;
   logic [4:0]        rs1_out, rs2_out, rd_out;
   logic [2:0]        wb_mux_sel_out, imm_type_out, csr_op_out;
   logic [3:0]        alu_opcode_out;
   logic [1:0]        load_size_out;
   logic              alu_src_out, iadder_src_out, rf_wr_en_out, mem_wr_req_out;
   logic              load_unsigned_out, csr_wr_en_out, illegal_instr_out;
   logic [$clog2(DEPTH):0] occupancy_out;
   logic [CNT_W-1:0]  illegal_cnt_out;

   always #5 clk_in = ~clk_in;

   decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in),
      .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
      .instr_in(instr_in), .pc_in(pc_in), .flush_in(flush_in), .mem_idle_in(mem_idle_in),
      .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in), .pc_out(pc_out),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
      .wb_mux_sel_out(wb_mux_sel_out), .imm_type_out(imm_type_out), .csr_op_out(csr_op_out),
      .alu_opcode_out(alu_opcode_out), .load_size_out(load_size_out),
      .alu_src_out(alu_src_out), .iadder_src_out(iadder_src_out), .rf_wr_en_out(rf_wr_en_out),
      .mem_wr_req_out(mem_wr_req_out), .load_unsigned_out(load_unsigned_out),
      .csr_wr_en_out(csr_wr_en_out), .illegal_instr_out(illegal_instr_out),
      .occupancy_out(occupancy_out), .illegal_cnt_out(illegal_cnt_out)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  wb, imm, csr_op;
      logic [3:0]  alu_op;
      logic [1:0]  ld_size;
      logic        alu_src, iadder_src, rf_wr, mem_wr, ld_uns, csr_wr, illegal;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        model_q[$];
   int          fence_stage = 0;   // 0 free, 1 waiting for FENCE to leave, 2 waiting for mem idle
   int unsigned cnt_model   = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference decoder: per-instruction-class table of field values.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t       e;
      logic [2:0] f3;
      f3 = ins[14:12];
      e = '0;
      e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.ld_size = f3[1:0]; e.ld_uns = f3[2];
      e.alu_src = ins[5];
      e.alu_op  = {ins[30], f3};
      if (ins[1:0] != 2'b11) e.illegal = 1'b1;
      else begin
         case (ins[6:2])
            5'b01100: e.rf_wr = 1'b1;                                            // OP
            5'b00100: begin e.imm = 3'd1; e.rf_wr = 1'b1;                        // OP-IMM
                      if (f3 != 3'd1 && f3 != 3'd5) e.alu_op[3] = 1'b0; end
            5'b00000: begin e.wb = 3'd1; e.imm = 3'd1; e.rf_wr = 1'b1; e.iadder_src = 1'b1; end
            5'b01000: begin e.imm = 3'd2; e.mem_wr = 1'b1; e.iadder_src = 1'b1; end
            5'b11000: e.imm = 3'd3;                                              // BRANCH
            5'b11011: begin e.wb = 3'd5; e.imm = 3'd5; e.rf_wr = 1'b1; end       // JAL
            5'b11001: begin e.wb = 3'd5; e.imm = 3'd1; e.rf_wr = 1'b1; e.iadder_src = 1'b1; end
            5'b01101: begin e.wb = 3'd2; e.imm = 3'd4; e.rf_wr = 1'b1; end       // LUI
            5'b00101: begin e.wb = 3'd3; e.imm = 3'd4; e.rf_wr = 1'b1; end       // AUIPC
            5'b00011: ;                                                          // FENCE
            5'b11100: begin
               if (f3 != 3'd0) begin
`ifdef DECODE_CSR_EN
                  e.wb = 3'd4; e.imm = 3'd6; e.rf_wr = 1'b1; e.csr_wr = 1'b1; e.csr_op = f3;
`else
                  e.illegal = 1'b1;
`endif
               end
            end
            default: e.illegal = 1'b1;
         endcase
      end
      if (e.illegal) begin e.rf_wr = 1'b0; e.mem_wr = 1'b0; e.csr_wr = 1'b0; end
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.pc = pc_out; a.rs1 = rs1_out; a.rs2 = rs2_out; a.rd = rd_out;
      a.wb = wb_mux_sel_out; a.imm = imm_type_out; a.csr_op = csr_op_out;
      a.alu_op = alu_opcode_out; a.ld_size = load_size_out;
      a.alu_src = alu_src_out; a.iadder_src = iadder_src_out; a.rf_wr = rf_wr_en_out;
      a.mem_wr = mem_wr_req_out; a.ld_uns = load_unsigned_out; a.csr_wr = csr_wr_en_out;
      a.illegal = illegal_instr_out;
      return a;
   endfunction

   // One clock cycle, entered and left on a falling edge: drive, compare, advance model.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl, input bit idle);
      int   sz;
      bit   exp_ready, push, pop;
      exp_t e, e_head;
      instr_valid_in = v; instr_in = ins; pc_in = pc;
      dec_ready_in = rdy; flush_in = fl; mem_idle_in = idle;
      #1;
      sz        = model_q.size();
      exp_ready = (fence_stage == 0) && (sz < DEPTH);
      e_head    = (sz != 0) ? model_q[0] : '0;
      check("ready",       128'(instr_ready_out), 128'(exp_ready));
      check("dec_valid",   128'(dec_valid_out),   128'(sz != 0));
      check("occupancy",   128'(occupancy_out),   128'(sz));
      check("illegal_cnt", 128'(illegal_cnt_out), 128'(cnt_model));
      check("bundle",      128'(actual()),        128'(e_head));
      push = v && exp_ready;
      pop  = (sz != 0) && rdy;
      if (fl) begin
         model_q.delete();
         fence_stage = 0;
      end else begin
         if (fence_stage == 1 && sz == 0) fence_stage = 2;
         else if (fence_stage == 2 && idle) fence_stage = 0;
         if (pop) model_q.delete(0);
         if (push) begin
            e = ref_decode(ins, pc);
            model_q.push_back(e);
            if (e.illegal && cnt_model < CNT_MAX) cnt_model++;
            if (ins[6:0] == 7'b0001111) fence_stage = 1;
         end
      end
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [4:0]  opcs [11];
      int          k;
      opcs = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011,
               5'b11001, 5'b01101, 5'b00101, 5'b00011, 5'b11100};
      r = $urandom;
      k = $urandom_range(0, 12);
      if (k < 11)       r[6:0] = {opcs[k], 2'b11};
      else if (k == 11) r[1:0] = 2'($urandom_range(0, 2));
      else              r[6:0] = 7'b1010111;
      return r;
   endfunction

   localparam logic [31:0] ADD_X3   = 32'h002081B3;
   localparam logic [31:0] FENCE_I  = 32'h0FF0000F;
   localparam logic [31:0] CSRRW_I  = 32'h34029073;
   localparam logic [31:0] ADDI_A   = 32'h00100293;
   localparam logic [31:0] ADDI_B   = 32'h00200313;
   localparam logic [31:0] ADDI_C   = 32'h00300393;

   initial begin
      // ---- reset state ----
      @(negedge clk_in);
      @(negedge clk_in);
      check("rst_ready", 128'(instr_ready_out), 128'(1));
      check("rst_valid", 128'(dec_valid_out),   128'(0));
      check("rst_occ",   128'(occupancy_out),   128'(0));
      check("rst_cnt",   128'(illegal_cnt_out), 128'(0));
      check("rst_bundle",128'(actual()),        128'(0));
      reset_n_in = 1'b1;

      // ---- ADD x3,x1,x2 ----
      step(1, ADD_X3, 32'h100, 1, 0, 1);
      check("add_valid",  128'(dec_valid_out),  128'(1));
      check("add_aluop",  128'(alu_opcode_out), 128'(4'b0000));
      check("add_rfwr",   128'(rf_wr_en_out),   128'(1));
      check("add_rd",     128'(rd_out),         128'(3));
      check("add_wbsel",  128'(wb_mux_sel_out), 128'(3'b000));
      step(0, 32'h0, 32'h0, 1, 0, 1);

      // ---- back-pressure with 3 ADDIs ----
      step(1, ADDI_A, 32'h200, 0, 0, 1);
      step(1, ADDI_B, 32'h204, 0, 0, 1);
      step(1, ADDI_C, 32'h208, 0, 0, 1);
      check("bp_occ",   128'(occupancy_out),   128'(2));
      check("bp_ready", 128'(instr_ready_out), 128'(0));
      check("bp_pc0",   128'(pc_out),          128'(32'h200));
      step(0, 32'h0, 32'h0, 1, 0, 1);
      check("bp_pc1",   128'(pc_out),          128'(32'h204));
      step(0, 32'h0, 32'h0, 1, 0, 1);

      // ---- FENCE serialisation ----
      step(1, FENCE_I, 32'h300, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(1, ADDI_A, 32'h304, 1, 0, 0);
      check("fence_ready", 128'(instr_ready_out), 128'(0));
      check("fence_occ",   128'(occupancy_out),   128'(0));
      step(1, ADDI_A, 32'h304, 1, 0, 1);
      check("fence_release", 128'(instr_ready_out), 128'(1));
      step(1, ADDI_A, 32'h304, 1, 0, 1);
      step(0, 32'h0, 32'h0, 1, 0, 1);

      // ---- illegal counter saturation ----
      for (int i = 0; i < 300; i++)
         step(1, {$urandom} | 32'h7F, 32'h400 + 32'(i * 4), 1, 0, 1);
      check("sat_cnt",     128'(illegal_cnt_out),   128'(CNT_MAX));
      check("sat_illegal", 128'(illegal_instr_out), 128'(1));
      check("sat_rfwr",    128'(rf_wr_en_out),      128'(0));
      step(0, 32'h0, 32'h0, 1, 0, 1);

      // ---- flush with simultaneous push ----
      step(1, ADDI_A, 32'h500, 0, 0, 1);
      step(1, ADDI_B, 32'h504, 0, 0, 1);
      step(1, ADDI_C, 32'h508, 1, 1, 1);
      check("flush_occ",   128'(occupancy_out),   128'(0));
      check("flush_valid", 128'(dec_valid_out),   128'(0));
      check("flush_ready", 128'(instr_ready_out), 128'(1));

      // ---- CSRRW ----
      step(1, CSRRW_I, 32'h600, 1, 0, 1);
`ifdef DECODE_CSR_EN
      check("csr_wr", 128'(csr_wr_en_out), 128'(1));
      check("csr_op", 128'(csr_op_out),    128'(3'b001));
`else
      check("csr_illegal", 128'(illegal_instr_out), 128'(1));
      check("csr_wr",      128'(csr_wr_en_out),     128'(0));
`endif
      step(0, 32'h0, 32'h0, 1, 0, 1);

      // ---- asynchronous reset mid-operation ----
      step(1, ADDI_A, 32'h700, 0, 0, 1);
      step(1, ADDI_B, 32'h704, 0, 0, 1);
      instr_valid_in = 1'b0;
      #2 reset_n_in = 1'b0;
      #1;
      check("arst_valid",  128'(dec_valid_out),   128'(0));
      check("arst_occ",    128'(occupancy_out),   128'(0));
      check("arst_ready",  128'(instr_ready_out), 128'(1));
      check("arst_cnt",    128'(illegal_cnt_out), 128'(0));
      check("arst_bundle", 128'(actual()),        128'(0));
      model_q.delete();
      fence_stage = 0;
      cnt_model   = 0;
      @(negedge clk_in);
      reset_n_in = 1'b1;

      // ---- random traffic ----
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
              $urandom_range(0, 1) == 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled RV32I instruction decode stage. It accepts raw 32-bit instructions with their PC over a valid/ready handshake and decodes them into the control bundle the execute stage consumes. The decoded bundles are buffered in a parametrised FIFO. It adds three things the combinational decoder lacks: back-pressure, flush, and FENCE serialisation. Misalignment checks move to execute, because the effective address is not known here.

## Interface
- PC_W, 32, PC width in bits.
- DEPTH, 2, number of FIFO entries; power of two, ≥2.
- CNT_W, 8, width of the saturating illegal-instruction counter.

- clk_in  in  1  clock, rising edge.
- reset_n_in  in  1  reset, asynchronous, active-low.
- instr_valid_in  in  1  upstream instruction valid.
- instr_ready_out  out  1  stage can accept an instruction.
- instr_in  in  32  raw instruction.
- pc_in  in  PC_W  PC of instr_in.
- flush_in  in  1  discard all buffered and in-flight entries.
- mem_idle_in  in  1  load/store unit has no outstanding accesses.
- dec_valid_out  out  1  head bundle valid.
- dec_ready_in  in  1  execute consumes the head bundle.
- pc_out  out  PC_W; rs1_out, rs2_out, rd_out  out  5 each.
- wb_mux_sel_out, imm_type_out, csr_op_out  out  3 each; alu_opcode_out  out  4; load_size_out  out  2.
- alu_src_out, iadder_src_out, rf_wr_en_out, mem_wr_req_out, load_unsigned_out, csr_wr_en_out, illegal_instr_out  out  1 each.
- occupancy_out  out  $clog2(DEPTH)+1  current FIFO fill.
- illegal_cnt_out  out  CNT_W  accepted illegal instructions, saturating.

## Operation
- Decode is combinational on instr_in, and the result is pushed into the FIFO. Field rules match the existing RV32I decoder:
  - wb_mux_sel: bit0 = load|auipc|jal|jalr; bit1 = lui|auipc; bit2 = csr|jal|jalr.
  - imm_type: bit0 = op_imm|load|jalr|branch|jal; bit1 = store|branch|csr; bit2 = lui|auipc|jal|csr.
  - alu_opcode = {funct7[5] & ~(I-type arithmetic other than shifts), funct3}.
  - alu_src = opcode[5]; iadder_src = load|store|jalr.
  - load_size = funct3[1:0]; load_unsigned = funct3[2].
  - mem_wr_req = store (intent only; execute applies the misalign and trap gates).
- illegal_instr = opcode[1:0]≠2'b11 or unrecognised opcode[6:2].
- An illegal instruction is still pushed, with illegal_instr=1 and all write enables forced to 0.
- Push when instr_valid_in & instr_ready_out. Pop when dec_valid_out & dec_ready_in.
- FSM states:
  - RUN: instr_ready_out = ~full. Accepting a MISC_MEM instruction → FENCE_DRAIN.
  - FENCE_DRAIN: instr_ready_out=0. Once the FIFO is empty (the FENCE has been popped) → FENCE_IDLE.
  - FENCE_IDLE: instr_ready_out=0. When mem_idle_in=1 → RUN.
- flush_in has highest priority. Registered effects: pointers and count go to 0 and state goes to RUN. A same-cycle push and pop are ignored. illegal_cnt_out is not cleared by flush.
- illegal_cnt_out increments on each accepted illegal push (unless flush is asserted), saturating at all-ones.

## Timing
- Reset values:
  - All outputs 0, except instr_ready_out=1.
  - Bundle outputs 0 while the FIFO is empty.
  - FSM in RUN, illegal_cnt_out=0.
- Latency: an instruction accepted in cycle N appears on dec_valid_out in cycle N+1. There is no combinational bypass.
- instr_ready_out depends only on registered state; there is no path from dec_ready_in.
- Full FIFO with a simultaneous pop: ready stays 0 that cycle and the freed slot is visible the next cycle.
- Simultaneous push and pop when not full: occupancy is unchanged.
- Pointers wrap modulo DEPTH.
- Bundle outputs hold stable while dec_valid_out=1 and dec_ready_in=0.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously).

## Configuration
- DECODE_CSR_EN defined: a SYSTEM instruction with funct3≠0 is a CSR access, giving csr_wr_en=1, csr_op=funct3 and rf_wr_en=1.
- DECODE_CSR_EN undefined: such instructions are illegal_instr=1. csr_wr_en_out and csr_op_out are tied to 0. ECALL/EBREAK (funct3=0) remain legal.

## Structure
- decode_pkg holds:
  - opcode[6:2] and funct3 constants;
  - wb_mux_sel and imm_type encodings;
  - the packed dec_bundle_t struct (all bundle fields plus pc);
  - the FSM state enum.
- One sub-module, decode_fifo: a DEPTH×$bits(dec_bundle_t) synchronous FIFO with push, pop, flush, full, empty and count. The FSM and decode logic stay in decode_stage.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with dec_ready_in=1 → one cycle later dec_valid_out=1, alu_opcode=4'b0000, rf_wr_en=1, rd=3, wb_mux_sel=3'b000.
- dec_ready_in=0 while pushing 3 ADDIs with DEPTH=2 → 2 accepted, instr_ready_out=0, occupancy=2. Release ready → the ADDIs emerge in order, with the PCs unchanged.
- FENCE (0x0FF0000F) followed by an ADDI, with mem_idle_in=0 → ADDI held (ready=0) after the FENCE pops. Assert mem_idle_in → ready returns next cycle.
- opcode 7'b1111111 ×300 with CNT_W=8 → illegal_instr_out=1 per bundle, rf_wr_en=0, illegal_cnt_out saturates at 255.
- 2 entries buffered, flush_in pulsed with a simultaneous push → next cycle occupancy=0, dec_valid_out=0, state RUN.
- CSRRW (0x34029073) → with DECODE_CSR_EN: csr_wr_en=1, csr_op=3'b001. Without it: illegal_instr=1, csr_wr_en=0.
